// File: rtl/uart_8250_pkg.sv
`default_nettype none
// uart_8250_pkg: 8250 register map, LSR bit positions and the TX sequencer state encoding.
// Revision 1.0

package uart_8250_pkg;

  localparam logic [3:0] OFF_THR = 4'd0;
  localparam logic [3:0] OFF_IER = 4'd1;
  localparam logic [3:0] OFF_FCR = 4'd2;
  localparam logic [3:0] OFF_IIR = 4'd2;
  localparam logic [3:0] OFF_LCR = 4'd3;
  localparam logic [3:0] OFF_MCR = 4'd4;
  localparam logic [3:0] OFF_LSR = 4'd5;
  localparam logic [3:0] OFF_MSR = 4'd6;

  localparam int LSR_THRE = 5;
  localparam int LSR_DR   = 0;

  localparam logic [3:0] SEL_BYTE0 = 4'b0001;

  typedef enum logic [2:0] {
    ST_INIT_IER = 3'd0,
    ST_INIT_FCR = 3'd1,
    ST_INIT_LCR = 3'd2,
    ST_IDLE     = 3'd3,
    ST_POLL     = 3'd4,
    ST_GAP      = 3'd5,
    ST_WRITE    = 3'd6
  } seq_state_t;

endpackage

`default_nettype wire

// File: rtl/uart_byte_fifo.sv
`default_nettype none
// uart_byte_fifo: synchronous byte FIFO with a registered full flag.
// Revision 1.0

module uart_byte_fifo #(
  parameter int DEPTH = 16,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [7:0]    push_data,
  input  logic          pop,
  output logic [7:0]    head,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  logic [7:0]    mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count_r;
  logic [CW-1:0] count_next;
  logic          full_r;
  logic          push_ok;
  logic          pop_ok;

  assign push_ok = push & ~full_r;
  assign pop_ok  = pop & (count_r != '0);

  always_comb begin
    count_next = count_r;
    case ({push_ok, pop_ok})
      2'b10:   count_next = count_r + CW'(1);
      2'b01:   count_next = count_r - CW'(1);
      default: count_next = count_r;
    endcase
  end

  // Full is registered from the next count so producers see a glitch-free ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_r <= '0;
      full_r  <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PW'(1);
      count_r <= count_next;
      full_r  <= (count_next == CW'(DEPTH));
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

  assign head  = mem[rd_ptr];
  assign full  = full_r;
  assign empty = (count_r == '0);
  assign count = count_r;

endmodule

`default_nettype wire

// File: rtl/uart_8250_tx_sequencer.sv
`default_nettype none
// uart_8250_tx_sequencer: Wishbone master that initialises an 8250 and drains a byte FIFO into THR.
// Revision 1.0

module uart_8250_tx_sequencer
  import uart_8250_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h1250_0000,
  parameter int          FIFO_DEPTH  = 16,
  parameter int          TX_BURST    = 16,
  parameter int          POLL_GAP    = 8,
  parameter int          ACK_TIMEOUT = 255,
  parameter logic [7:0]  IER_INIT    = 8'h00,
  parameter logic [7:0]  FCR_INIT    = 8'h07,
  parameter logic [7:0]  LCR_INIT    = 8'h03
) (
  input  logic        CLK_I,
  input  logic        RST_I,
  output logic [31:0] ADR_O,
  output logic [31:0] DAT_O,
  input  logic [31:0] DAT_I,
  output logic        WE_O,
  output logic [3:0]  SEL_O,
  output logic        STB_O,
  output logic        CYC_O,
  input  logic        ACK_I,
  input  logic [7:0]  tx_data,
  input  logic        tx_valid,
  output logic        tx_ready,
  output logic        init_done,
  output logic        busy,
  output logic        err
);

  localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;
  localparam int WAIT_W  = $clog2(ACK_TIMEOUT + 1);
  localparam int GAP_W   = $clog2(POLL_GAP + 1);
  localparam int BURST_W = $clog2(TX_BURST + 1);

  seq_state_t         state;
  seq_state_t         state_next;
  logic               cyc;
  logic [31:0]        adr;
  logic [31:0]        dat;
  logic               we;
  logic [3:0]         sel;
  logic [WAIT_W-1:0]  wait_cnt;
  logic [GAP_W-1:0]   gap_cnt;
  logic [BURST_W-1:0] burst_cnt;
  logic               init_done_r;
  logic               err_r;

  logic               start;
  logic [3:0]         acc_off;
  logic               acc_we;
  logic [7:0]         acc_dat;
  logic               pop;
  logic               ack_hit;
  logic               timeout;
  logic               thre;

  logic [7:0]         fifo_head;
  logic               fifo_full;
  logic               fifo_empty;
  logic [CNT_W-1:0]   fifo_count;
  logic               unused_dat;

  uart_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (CLK_I),
    .rst       (RST_I),
    .push      (tx_valid),
    .push_data (tx_data),
    .pop       (pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Only a clean logic 1 on ACK_I ends a cycle; X/Z is treated as no ack.
  assign ack_hit = cyc & (ACK_I === 1'b1);
  assign timeout = cyc & ~ack_hit & (wait_cnt == WAIT_W'(ACK_TIMEOUT - 1));
  assign thre    = DAT_I[LSR_THRE];
  assign unused_dat = ^{DAT_I[31:LSR_THRE+1], DAT_I[LSR_THRE-1:0]};

  always_ff @(posedge CLK_I) begin
    if (RST_I) state <= ST_INIT_IER;
    else       state <= state_next;
  end

  // A new cycle may only start while cyc is low, which guarantees an idle cycle between accesses.
  always_comb begin
    state_next = state;
    start      = 1'b0;
    acc_off    = OFF_THR;
    acc_we     = 1'b0;
    acc_dat    = 8'h00;
    pop        = 1'b0;
    case (state)
      ST_INIT_IER: begin
        acc_off = OFF_IER;
        acc_we  = 1'b1;
        acc_dat = IER_INIT;
        start   = ~cyc;
        if (ack_hit) state_next = ST_INIT_FCR;
      end
      ST_INIT_FCR: begin
        acc_off = OFF_FCR;
        acc_we  = 1'b1;
        acc_dat = FCR_INIT;
        start   = ~cyc;
        if (ack_hit) state_next = ST_INIT_LCR;
      end
      ST_INIT_LCR: begin
        acc_off = OFF_LCR;
        acc_we  = 1'b1;
        acc_dat = LCR_INIT;
        start   = ~cyc;
        if (ack_hit) state_next = ST_IDLE;
      end
      ST_IDLE: begin
        if (!fifo_empty) state_next = ST_POLL;
      end
      ST_POLL: begin
        acc_off = OFF_LSR;
        start   = ~cyc;
        if (ack_hit) state_next = thre ? ST_WRITE : ST_GAP;
      end
      ST_GAP: begin
        acc_off = OFF_LSR;
        if (gap_cnt == GAP_W'(POLL_GAP - 1)) begin
          state_next = ST_POLL;
          start      = 1'b1;
        end
      end
      ST_WRITE: begin
        acc_off = OFF_THR;
        acc_we  = 1'b1;
        acc_dat = fifo_head;
        if (ack_hit) begin
          pop = 1'b1;
        end else if (!cyc) begin
          if (fifo_empty)                          state_next = ST_IDLE;
          else if (burst_cnt == BURST_W'(TX_BURST)) state_next = ST_POLL;
          else                                     start      = 1'b1;
        end
      end
      default: state_next = ST_INIT_IER;
    endcase
  end

  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      cyc         <= 1'b0;
      adr         <= BASE_ADDR;
      dat         <= 32'h0;
      we          <= 1'b0;
      sel         <= 4'h0;
      wait_cnt    <= '0;
      gap_cnt     <= '0;
      burst_cnt   <= '0;
      init_done_r <= 1'b0;
      err_r       <= 1'b0;
    end else begin
      if (start) begin
        cyc      <= 1'b1;
        adr      <= BASE_ADDR | {28'h0, acc_off};
        dat      <= {24'h0, acc_dat};
        we       <= acc_we;
        sel      <= SEL_BYTE0;
        wait_cnt <= '0;
      end else if (ack_hit || timeout) begin
        cyc <= 1'b0;
        we  <= 1'b0;
        sel <= 4'h0;
      end else if (cyc) begin
        wait_cnt <= wait_cnt + WAIT_W'(1);
      end
      if (timeout) err_r <= 1'b1;
      gap_cnt <= (state == ST_GAP) ? gap_cnt + GAP_W'(1) : '0;
      if (state == ST_POLL && ack_hit && thre) burst_cnt <= '0;
      else if (pop)                            burst_cnt <= burst_cnt + BURST_W'(1);
      if (state == ST_INIT_LCR && ack_hit) init_done_r <= 1'b1;
    end
  end

  assign ADR_O     = adr;
  assign DAT_O     = dat;
  assign WE_O      = we;
  assign SEL_O     = sel;
  assign STB_O     = cyc;
  assign CYC_O     = cyc;
  assign tx_ready  = ~fifo_full;
  assign init_done = init_done_r;
  assign busy      = (fifo_count != '0) | cyc;
  assign err       = err_r;

endmodule

`default_nettype wire

// File: tb/tb_uart_8250_tx_sequencer.sv
`default_nettype none
// tb_uart_8250_tx_sequencer: directed bench with a simple Wishbone slave model and bus-cycle log.
// Revision 1.0

module tb_uart_8250_tx_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] adr, dat_o, dat_i;
  logic        we, stb, cyc, ack;
  logic [3:0]  sel;
  logic [7:0]  tx_data;
  logic        tx_valid, tx_ready, init_done, busy, err;

  int n_vec = 0;
  int n_err = 0;

  bit         ack_en, ack_wr_block, hold_thre;
  logic [7:0] lsr_ok;
  int         zero_until = 0;

  always #5 clk = ~clk;

  uart_8250_tx_sequencer dut (
    .CLK_I(clk), .RST_I(rst), .ADR_O(adr), .DAT_O(dat_o), .DAT_I(dat_i),
    .WE_O(we), .SEL_O(sel), .STB_O(stb), .CYC_O(cyc), .ACK_I(ack),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .init_done(init_done), .busy(busy), .err(err)
  );

  // Slave model: zero-wait ack; LSR reads return 0 while held or for a scripted number of polls.
  int n_reads = 0;
  assign ack   = ack_en & cyc & stb & ~(we & ack_wr_block);
  assign dat_i = {24'h0, (hold_thre || (n_reads < zero_until)) ? 8'h00 : lsr_ok};

  int          cyc_n = 0, hi_run = 0, last_run = 0, b2b = 0;
  bit          last_acked = 1'b0;
  logic        log_we[$];
  logic [31:0] log_adr[$];
  logic [31:0] log_dat[$];
  int          log_rise[$];

  always @(posedge clk) begin
    cyc_n <= cyc_n + 1;
    if (cyc) hi_run <= hi_run + 1;
    else begin
      if (hi_run != 0) last_run <= hi_run;
      hi_run <= 0;
    end
    last_acked <= cyc & stb & (ack === 1'b1);
    if (last_acked && cyc) b2b <= b2b + 1;
    if (!rst && cyc && stb && ack === 1'b1) begin
      log_we.push_back(we);
      log_adr.push_back(adr);
      log_dat.push_back(we ? dat_o : dat_i);
      log_rise.push_back(cyc_n - hi_run);
      if (!we) n_reads <= n_reads + 1;
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    log_we.delete();
    log_adr.delete();
    log_dat.delete();
    log_rise.delete();
  endtask

  task automatic wait_log(input string tag, input int n, input int budget);
    int t = 0;
    while (log_adr.size() < n && t < budget) begin
      tick(1);
      t++;
    end
    check_val(tag, log_adr.size(), n);
  endtask

  task automatic push_byte(input logic [7:0] b);
    int t = 0;
    bit acc = 1'b0;
    tx_data  = b;
    tx_valid = 1'b1;
    while (!acc && t < 2000) begin
      acc = tx_ready;
      tick(1);
      t++;
    end
    tx_valid = 1'b0;
    if (!acc) check_val("push_accept", acc, 1);
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int t = 0;
    while (busy && t < budget) begin
      tick(1);
      t++;
    end
    check_val(tag, busy, 0);
  endtask

  function automatic int count_writes();
    int c = 0;
    foreach (log_we[i]) if (log_we[i]) c++;
    return c;
  endfunction

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int  nw, nr_after, pos, t;
    bit  acc;
    rst = 1'b1; tx_valid = 1'b0; tx_data = 8'h00;
    ack_en = 1'b1; ack_wr_block = 1'b0; hold_thre = 1'b0; lsr_ok = 8'h60;
    tick(3);

    // Reset state
    check_val("rst_cyc",   {cyc, stb, we}, 3'b000);
    check_val("rst_adr",   adr, 32'h1250_0000);
    check_val("rst_dat",   dat_o, 32'h0);
    check_val("rst_sel",   sel, 4'h0);
    check_val("rst_flags", {init_done, err, busy}, 3'b000);
    check_val("rst_ready", tx_ready, 1);

    // 1: init sequence
    clear_log();
    rst = 1'b0;
    wait_log("init_count", 3, 50);
    check_val("init_ier_adr", log_adr[0], 32'h1250_0001);
    check_val("init_ier_dat", log_dat[0], 32'h0000_0000);
    check_val("init_fcr_adr", log_adr[1], 32'h1250_0002);
    check_val("init_fcr_dat", log_dat[1], 32'h0000_0007);
    check_val("init_lcr_adr", log_adr[2], 32'h1250_0003);
    check_val("init_lcr_dat", log_dat[2], 32'h0000_0003);
    check_val("init_we", {log_we[0], log_we[1], log_we[2]}, 3'b111);
    check_val("init_gap01", log_rise[1] - log_rise[0], 2);
    check_val("init_gap12", log_rise[2] - log_rise[1], 2);
    check_val("init_done", init_done, 1);

    // 2: single byte, THRE already set
    clear_log();
    push_byte(8'h41);
    wait_log("t2_count", 2, 100);
    check_val("t2_poll", {log_we[0], log_adr[0]}, {1'b0, 32'h1250_0005});
    check_val("t2_wr",   {log_we[1], log_adr[1]}, {1'b1, 32'h1250_0000});
    check_val("t2_dat",  log_dat[1], 32'h0000_0041);
    tick(2);
    check_val("t2_busy", busy, 0);

    // 3: three polls without THRE, then one with it
    lsr_ok = 8'h20;
    clear_log();
    zero_until = n_reads + 3;
    push_byte(8'h55);
    wait_log("t3_count", 5, 300);
    tick(20);
    check_val("t3_total", log_adr.size(), 5);
    for (int i = 0; i < 4; i++) begin
      check_val($sformatf("t3_poll%0d", i), {log_we[i], log_adr[i]}, {1'b0, 32'h1250_0005});
      check_val($sformatf("t3_lsr%0d", i), log_dat[i], (i == 3) ? 32'h20 : 32'h0);
    end
    for (int i = 0; i < 3; i++)
      check_val($sformatf("t3_space%0d", i), log_rise[i+1] - log_rise[i], 9);
    check_val("t3_wr",  {log_we[4], log_adr[4]}, {1'b1, 32'h1250_0000});
    check_val("t3_dat", log_dat[4], 32'h55);

    // 4+5: fill FIFO while THRE held low, back-pressure, then 20-byte drain
    clear_log();
    hold_thre = 1'b1;
    for (int i = 0; i < 16; i++) push_byte(8'hA0 + 8'(i));
    check_val("t5_full", tx_ready, 0);
    tx_data = 8'hB0; tx_valid = 1'b1;
    tick(5);
    check_val("t5_held", tx_ready, 0);
    check_val("t5_nowr", count_writes(), 0);
    hold_thre = 1'b0;
    t = 0; acc = 1'b0;
    while (!acc && t < 200) begin
      acc = tx_ready;
      tick(1);
      t++;
    end
    tx_valid = 1'b0;
    check_val("t5_accept", acc, 1);
    check_val("t5_one_pop", count_writes(), 1);
    for (int i = 17; i < 20; i++) push_byte(8'hA0 + 8'(i));
    wait_idle("t4_idle", 500);
    nw = 0; nr_after = 0; pos = -1;
    foreach (log_we[j]) begin
      if (log_we[j]) begin
        check_val($sformatf("t4_byte%0d", nw), log_dat[j], 32'hA0 + nw);
        nw++;
      end else if (nw > 0) begin
        nr_after++;
        pos = nw;
      end
    end
    check_val("t4_writes", nw, 20);
    check_val("t4_repolls", nr_after, 1);
    check_val("t4_burst", pos, 16);
    check_val("bus_idle_gap", b2b, 0);

    // 6: ack timeout on a THR write, retry, then reset mid-cycle
    clear_log();
    ack_wr_block = 1'b1;
    check_val("t6_err_pre", err, 0);
    push_byte(8'h5A);
    t = 0;
    while (!err && t < 600) begin
      tick(1);
      t++;
    end
    check_val("t6_err", err, 1);
    tick(1);
    check_val("t6_run", last_run, 255);
    check_val("t6_retry", {cyc, we}, 2'b11);
    check_val("t6_retry_adr", adr, 32'h1250_0000);
    check_val("t6_retry_dat", dat_o, 32'h0000_005A);
    rst = 1'b1;
    tick(1);
    check_val("t6_rst_cyc", cyc, 0);
    check_val("t6_rst_flags", {busy, init_done, err}, 3'b000);
    check_val("t6_rst_ready", tx_ready, 1);
    ack_wr_block = 1'b0;
    clear_log();
    rst = 1'b0;
    wait_log("t6_reinit", 1, 50);
    check_val("t6_reinit_adr", log_adr[0], 32'h1250_0001);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
